i2c_passthru_outdrv: RTL
========================

# i2c_passthru_outdrv

Open-drain output sequencer for the I2C passthrough. It takes the core's requested SCL/SDA levels and drives pull-low enables onto the bus. Every change respects data hold and setup windows, minimum SCL low and high times, and clock stretching by other devices. It is the transmit-side counterpart of the input filter, and it consumes the filtered SCL level that the filter produces.

## Interface
Parameters:
- NUM_CLKS_WIDTH, 4: width of all internal counters. Every NUM_CLKS_* value must be ≤ 2^NUM_CLKS_WIDTH-1.
- NUM_CLKS_SDA_HOLD, 3: minimum clocks from an SCL edge before SDA may change. The SCL edge is SCL pulled low in S_LO, or a START in S_HI.
- NUM_CLKS_SDA_SETUP, 2: minimum clocks from an SDA change, or from SCL going high, before the next SCL release or START/STOP.
- NUM_CLKS_SCL_MIN_LO, 8: minimum clocks that SCL is held low by this block.
- NUM_CLKS_SCL_MIN_HI, 8: minimum clocks of bus SCL high before this block pulls SCL low.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sda_req  in  1  requested SDA level: 1 = release, 0 = pull low.
- i_scl_req  in  1  requested SCL level: 1 = release, 0 = pull low.
- i_scl_bus  in  1  filtered bus SCL level, taken from the input filter's o_scl.
- o_sda_oe  out  1  1 = drive SDA low.
- o_scl_oe  out  1  1 = drive SCL low.
- o_stretch  out  1  registered. High while SCL is released by this block but the bus is still low.
- o_busy  out  1  combinational: (i_sda_req == o_sda_oe) | (i_scl_req == o_scl_oe). This is a pending request not yet applied.

## Operation
- Registers:
  - state ∈ {S_LO, S_WAIT, S_HI}.
  - phase_cnt: cycles since entering the current state.
  - sda_cnt: cycles since the last SDA change.
  - Both counters increment every cycle and saturate at 2^NUM_CLKS_WIDTH-1 (no wrap).
- Reset state: state=S_WAIT, o_sda_oe=0, o_scl_oe=0, o_stretch=0, phase_cnt=0, sda_cnt=0.
  - sda_cnt resets to 0; the first SDA change is gated only by the state rules below.
- Pending SDA request: sda_pend = (i_sda_req == o_sda_oe).
- S_LO (this block drives SCL low):
  - If sda_pend and phase_cnt ≥ SDA_HOLD: o_sda_oe ← ~i_sda_req and sda_cnt ← 0.
  - Else, if i_scl_req=1 and !sda_pend and phase_cnt ≥ SCL_MIN_LO and sda_cnt ≥ SDA_SETUP: o_scl_oe ← 0, state ← S_WAIT, phase_cnt ← 0.
- S_WAIT (SCL released, waiting for the bus):
  - No output changes. All requests are deferred.
  - o_stretch ← ~i_scl_bus.
  - If i_scl_bus=1: state ← S_HI, phase_cnt ← 0, o_stretch ← 0.
- S_HI (bus SCL high):
  - If i_scl_bus=0 (another device pulled SCL low): state ← S_WAIT, phase_cnt ← 0, no output change. This check has top priority.
  - Else, if sda_pend and phase_cnt ≥ SDA_SETUP: o_sda_oe ← ~i_sda_req and sda_cnt ← 0. This is a START or STOP.
  - Else, if i_scl_req=0 and !sda_pend and phase_cnt ≥ SCL_MIN_HI and sda_cnt ≥ SDA_HOLD: o_scl_oe ← 1, state ← S_LO, phase_cnt ← 0.
- SDA and SCL never change in the same cycle. SDA has priority, and SCL is blocked while an SDA change is pending.
- Arbitration-loss detection is out of scope.

## Timing
- A counter cleared on edge k reads 0 at edge k+1.
- A threshold N therefore permits an action at edge k+N+1.
- In S_LO: SDA changes HOLD+1 clocks after o_scl_oe rises (4 with defaults). SCL releases no earlier than MIN_LO+1 clocks after o_scl_oe rises (9 with defaults).
- The S_WAIT→S_HI transition happens on the first edge at which i_scl_bus=1 is sampled. o_stretch falls on that same edge.
- If i_rst is asserted mid-operation, both oe outputs drop on the next edge, which releases the bus, and the state goes to S_WAIT.
- If i_rst is asserted while SCL is driven low, that low phase is truncated.

## Test plan
- Reset, then hold i_scl_bus=1 with both requests =1 → outputs stay 0. State reaches S_HI one edge after reset deasserts. o_busy=0 throughout.
- START and first clock:
  - Stimulus: in S_HI with phase_cnt ≥ 8, set i_sda_req=0 and i_scl_req=0 together.
  - o_sda_oe rises on the next edge.
  - o_scl_oe rises 4 edges after that (sda_cnt ≥ HOLD=3).
  - o_busy stays high until o_scl_oe rises.
- Data bit in S_LO:
  - Stimulus: o_scl_oe rises at edge 0, i_sda_req toggles at edge 0, i_scl_req=1.
  - o_sda_oe toggles at edge 4.
  - o_scl_oe falls at edge 9.
- Clock stretch:
  - Stimulus: after release, hold i_scl_bus=0 for 20 clocks.
  - o_stretch is high from edge 1 through edge 20. No oe changes during this window, even if i_sda_req toggles.
  - Once the bus goes high, o_stretch falls on the first edge that samples i_scl_bus=1.
- STOP:
  - Stimulus: in S_LO with o_sda_oe=1; i_scl_req=1, then i_sda_req=1 after SCL goes high.
  - After i_scl_bus is seen high, o_sda_oe falls 3 edges later (SETUP+1).
- Reset mid-bit: assert i_rst while o_scl_oe=1 and o_sda_oe=1 → both outputs read 0 after the next edge, and o_stretch=0.

Source files
------------

// File: rtl/i2c_passthru_outdrv.sv
// Open-drain output sequencer for the I2C passthrough: turns requested SCL/SDA
// levels into pull-low enables while honouring hold/setup, SCL low/high minimums and stretching.
module i2c_passthru_outdrv #(
  parameter int NUM_CLKS_WIDTH      = 4,
  parameter int NUM_CLKS_SDA_HOLD   = 3,
  parameter int NUM_CLKS_SDA_SETUP  = 2,
  parameter int NUM_CLKS_SCL_MIN_LO = 8,
  parameter int NUM_CLKS_SCL_MIN_HI = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sda_req,
  input  logic i_scl_req,
  input  logic i_scl_bus,
  output logic o_sda_oe,
  output logic o_scl_oe,
  output logic o_stretch,
  output logic o_busy
);
  localparam int W = NUM_CLKS_WIDTH;
  localparam logic [W-1:0] C_MAX    = '1;
  localparam logic [W-1:0] C_HOLD   = W'(NUM_CLKS_SDA_HOLD);
  localparam logic [W-1:0] C_SETUP  = W'(NUM_CLKS_SDA_SETUP);
  localparam logic [W-1:0] C_MIN_LO = W'(NUM_CLKS_SCL_MIN_LO);
  localparam logic [W-1:0] C_MIN_HI = W'(NUM_CLKS_SCL_MIN_HI);

  typedef enum logic [1:0] {S_LO, S_WAIT, S_HI} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_phase_cnt, r_sda_cnt;
  logic           r_sda_oe, r_scl_oe, r_stretch;
  logic           w_sda_nxt, w_scl_nxt, w_stretch_nxt;
  logic           w_ph_clr, w_sda_clr, w_sda_pend;

  function automatic logic [W-1:0] f_sat_inc(input logic [W-1:0] v);
    return (v == C_MAX) ? v : v + 1'b1;
  endfunction

  assign w_sda_pend = (i_sda_req == r_sda_oe);

  // SDA always wins over SCL in a cycle; a pending SDA change blocks SCL.
  always_comb begin
    w_state_nxt   = r_state;
    w_sda_nxt     = r_sda_oe;
    w_scl_nxt     = r_scl_oe;
    w_stretch_nxt = 1'b0;
    w_ph_clr      = 1'b0;
    w_sda_clr     = 1'b0;
    case (r_state)
      S_LO: begin
        if (w_sda_pend && r_phase_cnt >= C_HOLD) begin
          w_sda_nxt = ~i_sda_req;
          w_sda_clr = 1'b1;
        end else if (i_scl_req && !w_sda_pend && r_phase_cnt >= C_MIN_LO &&
                     r_sda_cnt >= C_SETUP) begin
          w_scl_nxt   = 1'b0;
          w_state_nxt = S_WAIT;
          w_ph_clr    = 1'b1;
        end
      end
      S_WAIT: begin
        w_stretch_nxt = ~i_scl_bus;
        if (i_scl_bus) begin
          w_state_nxt = S_HI;
          w_ph_clr    = 1'b1;
        end
      end
      S_HI: begin
        if (!i_scl_bus) begin
          // another master/target pulled SCL low under us
          w_state_nxt = S_WAIT;
          w_ph_clr    = 1'b1;
        end else if (w_sda_pend && r_phase_cnt >= C_SETUP) begin
          w_sda_nxt = ~i_sda_req;
          w_sda_clr = 1'b1;
        end else if (!i_scl_req && !w_sda_pend && r_phase_cnt >= C_MIN_HI &&
                     r_sda_cnt >= C_HOLD) begin
          w_scl_nxt   = 1'b1;
          w_state_nxt = S_LO;
          w_ph_clr    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
        w_ph_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_WAIT;
      r_sda_oe    <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_stretch   <= 1'b0;
      r_phase_cnt <= '0;
      r_sda_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sda_oe    <= w_sda_nxt;
      r_scl_oe    <= w_scl_nxt;
      r_stretch   <= w_stretch_nxt;
      r_phase_cnt <= w_ph_clr  ? '0 : f_sat_inc(r_phase_cnt);
      r_sda_cnt   <= w_sda_clr ? '0 : f_sat_inc(r_sda_cnt);
    end
  end

  assign o_sda_oe  = r_sda_oe;
  assign o_scl_oe  = r_scl_oe;
  assign o_stretch = r_stretch;
  assign o_busy    = (i_sda_req == r_sda_oe) | (i_scl_req == r_scl_oe);

endmodule
